// File: rtl/ibex_mem_bridge.sv
// Merges the Ibex instruction and data OBI ports onto one single-port SPRAM with 1-cycle read latency.
// Define IBEX_MEM_BRIDGE_RANGE_ERR_EN to flag accesses outside the memory window as bus errors.
module ibex_mem_bridge #(
  parameter int unsigned MEM_WORDS = 32768,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  input  logic [31:0]   instr_addr_i,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          data_req_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam logic [1:0] RESP_NONE  = 2'd0;
  localparam logic [1:0] RESP_INSTR = 2'd1;
  localparam logic [1:0] RESP_DATA  = 2'd2;

  logic [1:0] starve_q, starve_d;
  logic [1:0] resp_port_q, resp_port_d;
  logic       resp_we_q, resp_we_d;
  logic       resp_err_q, resp_err_d;
  logic       instr_oor, data_oor, acc_err, any_gnt, rd_ok;
  logic       unused_addr;

  assign unused_addr = ^{instr_addr_i, data_addr_i};

`ifdef IBEX_MEM_BRIDGE_RANGE_ERR_EN
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  logic [31:0] instr_off, data_off;
  assign instr_off = instr_addr_i - BASE_ADDR;
  assign data_off  = data_addr_i - BASE_ADDR;
  assign instr_oor = ({1'b0, instr_off} >= MEM_BYTES);
  assign data_oor  = ({1'b0, data_off} >= MEM_BYTES);
`else
  assign instr_oor = 1'b0;
  assign data_oor  = 1'b0;
`endif

  // Arbitration: data wins unless instr has lost twice in a row.
  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && (!data_req_i || starve_q == 2'd2)) begin
        instr_gnt_o = 1'b1;
      end else if (data_req_i) begin
        data_gnt_o = 1'b1;
      end
    end
  end

  assign any_gnt     = instr_gnt_o | data_gnt_o;
  assign acc_err     = instr_gnt_o ? instr_oor : (data_gnt_o & data_oor);
  assign mem_en_o    = any_gnt & ~acc_err;
  assign mem_we_o    = mem_en_o & data_gnt_o & data_we_i;
  assign mem_be_o    = data_gnt_o ? data_be_i : 4'b0000;
  assign mem_addr_o  = instr_gnt_o ? instr_addr_i[AW+1:2] : data_addr_i[AW+1:2];
  assign mem_wdata_o = data_wdata_i;

  always_comb begin
    starve_d = starve_q;
    if (instr_gnt_o || !instr_req_i) begin
      starve_d = 2'd0;
    end else if (data_gnt_o) begin
      starve_d = starve_q + 2'd1;
    end
    resp_port_d = instr_gnt_o ? RESP_INSTR : (data_gnt_o ? RESP_DATA : RESP_NONE);
    resp_we_d   = data_gnt_o & data_we_i;
    resp_err_d  = any_gnt & acc_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q    <= 2'd0;
      resp_port_q <= RESP_NONE;
      resp_we_q   <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      resp_port_q <= resp_port_d;
      resp_we_q   <= resp_we_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Response stage: a response due while reset is asserted is dropped.
  assign instr_rvalid_o = ~rst_i & (resp_port_q == RESP_INSTR);
  assign data_rvalid_o  = ~rst_i & (resp_port_q == RESP_DATA);
  assign rd_ok          = ~resp_we_q & ~resp_err_q;
  assign instr_rdata_o  = (instr_rvalid_o && rd_ok) ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_o && rd_ok) ? mem_rdata_i : 32'h0;

`ifdef IBEX_MEM_BRIDGE_RANGE_ERR_EN
  assign instr_err_o = instr_rvalid_o & resp_err_q;
  assign data_err_o  = data_rvalid_o & resp_err_q;
`else
  assign instr_err_o = 1'b0;
  assign data_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_mem_bridge.sv
// Directed bench for ibex_mem_bridge with a behavioural SPRAM model (1-cycle read latency).
module tb_ibex_mem_bridge;
  localparam int MW  = 1024;
  localparam int AWL = 10;
`ifdef IBEX_MEM_BRIDGE_RANGE_ERR_EN
  localparam bit RE = 1'b1;
`else
  localparam bit RE = 1'b0;
`endif

  logic           clk, rst;
  logic           instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0]    instr_addr, instr_rdata;
  logic           data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]     data_be;
  logic [31:0]    data_addr, data_wdata, data_rdata;
  logic           mem_en, mem_we;
  logic [3:0]     mem_be;
  logic [AWL-1:0] mem_addr;
  logic [31:0]    mem_wdata, mem_rdata;

  logic [31:0] mem [MW];
  int n_tests = 0;
  int n_fail  = 0;

  ibex_mem_bridge #(.MEM_WORDS(MW), .BASE_ADDR(32'h0)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
    instr_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        we;
    logic [3:0]  be;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic        igr, dgr, en;
    logic        irv, drv;
    logic [31:0] irdata, drdata;
    logic        ierr, derr;
  } vec_t;

  vec_t vecs[9];
  logic [5:0] pat;
  logic       prev_i, prev_d;

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = 32'h0;
    mem[0]    = 32'hCAFEF00D;
    mem[16]   = 32'hDEADBEEF;
    mem[64]   = 32'h11223344;
    mem_rdata = 32'h0;
    idle();

    //            ireq iaddr        dreq we be     daddr        wdata          igr dgr en   irv drv irdata  drdata  ierr derr
    vecs[0] = '{1'b1, 32'h40,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,    1'b1, 1'b1, 4'h2, 32'h100, 32'h0000AB00,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0,    1'b1, 1'b0, 4'hF, 32'h100, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1122AB44, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,    1'b1, 1'b1, 4'hF, 32'h104, 32'hA5A5A5A5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h104,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0,    1'b1, 1'b1, 4'hF, 32'h1000, 32'h12345678, 1'b0, 1'b1, !RE, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, RE};
    vecs[6] = '{1'b0, 32'h0,    1'b1, 1'b0, 4'hF, 32'h0,   32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,
                (RE ? 32'hCAFEF00D : 32'h12345678), 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h1040, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1, 1'b0, !RE, 1'b1, 1'b0,
                (RE ? 32'h0 : 32'hDEADBEEF), 32'h0, RE, 1'b0};
    vecs[8] = '{1'b0, 32'h0,    1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};

    // Reset: grants forced low even with both requests high
    rst = 1'b1;
    instr_req = 1'b1; data_req = 1'b1;
    #2;
    chk("rst_instr_gnt", instr_gnt, 0);
    chk("rst_data_gnt", data_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", {instr_rvalid, data_rvalid}, 0);
    chk("rst_rdata", instr_rdata | data_rdata, 0);
    chk("rst_err", {instr_err, data_err}, 0);
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rvalid", {instr_rvalid, data_rvalid}, 0);

    for (int i = 0; i < 9; i++) begin
      instr_req = vecs[i].ireq; instr_addr = vecs[i].iaddr;
      data_req = vecs[i].dreq; data_we = vecs[i].we; data_be = vecs[i].be;
      data_addr = vecs[i].daddr; data_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_instr_gnt", i), instr_gnt, vecs[i].igr);
      chk($sformatf("v%0d_data_gnt", i), data_gnt, vecs[i].dgr);
      chk($sformatf("v%0d_mem_en", i), mem_en, vecs[i].en);
      @(posedge clk); #1;
      idle();
      #1;
      chk($sformatf("v%0d_instr_rvalid", i), instr_rvalid, vecs[i].irv);
      chk($sformatf("v%0d_data_rvalid", i), data_rvalid, vecs[i].drv);
      chk($sformatf("v%0d_instr_rdata", i), instr_rdata, vecs[i].irdata);
      chk($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].drdata);
      chk($sformatf("v%0d_instr_err", i), instr_err, vecs[i].ierr);
      chk($sformatf("v%0d_data_err", i), data_err, vecs[i].derr);
    end
    chk("oor_store_word0", mem[0], RE ? 32'hCAFEF00D : 32'h12345678);

    // Contention: both held for 6 cycles -> D,D,I,D,D,I
    pat = 6'b100100;
    prev_i = 1'b0; prev_d = 1'b0;
    instr_req = 1'b1; instr_addr = 32'h40;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("cont%0d_instr_gnt", k), instr_gnt, pat[k]);
      chk($sformatf("cont%0d_data_gnt", k), data_gnt, !pat[k]);
      if (k > 0) begin
        chk($sformatf("cont%0d_instr_rvalid", k), instr_rvalid, prev_i);
        chk($sformatf("cont%0d_data_rvalid", k), data_rvalid, prev_d);
        chk($sformatf("cont%0d_instr_rdata", k), instr_rdata, prev_i ? 32'hDEADBEEF : 32'h0);
        chk($sformatf("cont%0d_data_rdata", k), data_rdata, prev_d ? 32'h1122AB44 : 32'h0);
      end
      prev_i = pat[k]; prev_d = !pat[k];
      @(posedge clk); #1;
    end
    idle();
    #1;
    chk("cont_last_instr_rvalid", instr_rvalid, 1);
    chk("cont_last_instr_rdata", instr_rdata, 32'hDEADBEEF);
    chk("cont_last_data_rvalid", data_rvalid, 0);

    // Reset in the cycle after a data read grant drops the response
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h100;
    #1;
    chk("rmid_data_gnt", data_gnt, 1);
    @(posedge clk); #1;
    rst = 1'b1; instr_req = 1'b1;
    #1;
    chk("rmid_data_rvalid", data_rvalid, 0);
    chk("rmid_data_rdata", data_rdata, 0);
    chk("rmid_gnt", {instr_gnt, data_gnt}, 0);
    chk("rmid_mem_en", mem_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    #1;
    chk("rmid_after_rvalid", {instr_rvalid, data_rvalid}, 0);
    instr_req = 1'b1; instr_addr = 32'h40;
    #1;
    chk("rmid_instr_gnt", instr_gnt, 1);
    @(posedge clk); #1;
    idle();
    #1;
    chk("rmid_instr_rvalid", instr_rvalid, 1);
    chk("rmid_instr_rdata", instr_rdata, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ibex_mem_bridge.md
# ibex_mem_bridge

Memory-side bridge directly downstream of the Ibex core wrapper. It merges the core's instruction and data OBI-style ports (req/gnt/rvalid) onto a single-port 32-bit iCE40 SPRAM array with one-cycle read latency. It arbitrates between the two ports, generates grants and responses, and optionally flags out-of-range accesses as bus errors.

## Interface
Parameters:
- MEM_WORDS, 32768, number of 32-bit words in the backing memory; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*MEM_WORDS.
- AW, $clog2(MEM_WORDS), memory word-address width (derived).

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_req_i  in  1  instruction fetch request.
- instr_gnt_o  out  1  instruction request accepted this cycle.
- instr_rvalid_o  out  1  instruction response valid.
- instr_addr_i  in  32  fetch byte address; bits [1:0] ignored.
- instr_rdata_o  out  32  fetched word.
- instr_err_o  out  1  fetch error, qualified by instr_rvalid_o.
- data_req_i  in  1  load/store request.
- data_gnt_o  out  1  data request accepted this cycle.
- data_rvalid_o  out  1  data response valid.
- data_we_i  in  1  1 = store.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_wdata_i  in  32  store data.
- data_rdata_o  out  32  load data.
- data_err_o  out  1  data error, qualified by data_rvalid_o.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_be_o  out  4  memory byte write mask.
- mem_addr_o  out  AW  memory word address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  read data, valid the cycle after mem_en_o with mem_we_o=0.

## Operation
- At most one grant per cycle. Grant is combinational from req and arbitration state. Memory strobe is issued in the grant cycle.
- Arbitration: data has priority. A 2-bit starve counter increments each cycle in which data is granted while instr_req_i is high. It clears on any instr grant or any cycle where instr_req_i is low. When the counter equals 2 and both requests are high, instr is granted.
- Grant cycle drives mem_addr_o = addr[AW+1:2]. For data it drives mem_we_o = data_we_i, mem_be_o = data_be_i and mem_wdata_o = data_wdata_i. For instr it drives mem_we_o = 0 and mem_be_o = 4'b0000.
- Response register holds: port (NONE/INSTR/DATA), we, err. It loads on every grant and is set to NONE on cycles without a grant.
- Response cycle asserts the selected port's rvalid for exactly one cycle.
  - rdata = mem_rdata_i for non-error reads; otherwise rdata = 32'h0.
  - Stores also receive rvalid, with rdata 0.
- Non-selected rdata outputs are 32'h0.
- No backpressure on responses. The core always accepts rvalid.

## Timing
- Grant latency 0 cycles (same cycle as req). rvalid exactly 1 cycle after gnt.
- Throughput is one access per cycle. Back-to-back grants on either port are allowed, including alternating ports.
- Simultaneous requests: the data port wins unless starve = 2. The losing port keeps req high (OBI rule) and is granted later.
- Reset values:
  - Outputs: all rvalid/err = 0, rdata = 0, gnt = 0 (forced low while rst_i is high), mem_en_o = 0.
  - State: response register = NONE, starve counter = 0.
- Reset asserted mid-transaction: a response pending for the next cycle is dropped and no rvalid is issued. A grant in the cycle rst_i is high is impossible.
- mem_en_o = instr_gnt_o | data_gnt_o, except for error accesses (see Configuration).

## Configuration
- IBEX_MEM_BRIDGE_RANGE_ERR_EN defined:
  - An address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) is still granted, but mem_en_o stays 0 and no write occurs.
  - The response has err = 1 and rdata = 32'h0.
- Undefined:
  - Addresses are used modulo 4*MEM_WORDS relative to BASE_ADDR, so out-of-range accesses alias into memory.
  - err outputs are tied to 0, and the range comparators are not built.

## Test plan
- Instr-only read: preload word 0x10 = 32'hDEADBEEF; instr_req at addr 0x40 -> instr_gnt same cycle, instr_rvalid next cycle, instr_rdata = 32'hDEADBEEF, err 0.
- Byte store then load: data store addr 0x100, be 4'b0010, wdata 32'h0000AB00 onto a word preloaded with 32'h11223344. Then load the same address -> store gets rvalid with rdata 0. The load returns 32'h1122AB44.
- Contention/starvation: hold both reqs for 6 cycles -> grant sequence D,D,I,D,D,I. Each rvalid goes to the matching port one cycle later.
- Reset mid-op: assert rst_i in the cycle after a data read grant -> no data_rvalid, all outputs 0. After release the first request is serviced normally.
- Range error (macro defined): data store to BASE_ADDR+4*MEM_WORDS -> gnt, mem_en_o = 0, data_rvalid next cycle with data_err = 1 and memory unchanged. With the macro undefined, the same access writes word 0 and err = 0.
